// File: rtl/pause_arbiter_pkg.sv
// Shared types and default constants for the core pause arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pause_arbiter_pkg;

    // Arbiter states: running, waiting for a vblank to pause on,
    // paused (settling), paused with RAM granted to the hiscore engine.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_VBL = 2'd1,
        PAUSED   = 2'd2,
        GRANT    = 2'd3
    } state_t;

    // 10 s of user pause at 11 MHz before the screen dims.
    localparam int unsigned DIM_TIMEOUT_DEF  = 32'h068E7780;
    // Cycles the core must sit in pause before hiscore may touch its RAM.
    localparam int unsigned SETTLE_CYC_DEF   = 4;
    // Upper bound on the vblank wait so a stalled video timing cannot block pause.
    localparam int unsigned VBL_WAIT_MAX_DEF = 200000;
    // Packed RGB width, three equal channels.
    localparam int unsigned RGB_W_DEF        = 6;

endpackage

// File: rtl/pause_arbiter_rgb_dimmer.sv
// RGB dimmer: registers the core RGB, halving every channel while dim is set.
// Latency: 1 clk from rgb_in/dim to rgb_out.
// Backpressure: none, streams every cycle.
// Ports: clk, reset_n (async active-low), dim, rgb_in[RGB_W], rgb_out[RGB_W].
module pause_arbiter_rgb_dimmer #(
    parameter int unsigned RGB_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dim,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [RGB_W-1:0] rgb_out
);

    localparam int unsigned CH_W = RGB_W / 3;

    logic [RGB_W-1:0] rgb_half;

    // Shift each channel on its own so no bit leaks into the channel below.
    always_comb begin
        rgb_half = '0;
        for (int c = 0; c < 3; c++) begin
            rgb_half[c*CH_W +: CH_W] = rgb_in[c*CH_W +: CH_W] >> 1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= dim ? rgb_half : rgb_in;
        end
    end

endmodule

// File: rtl/pause_arbiter.sv
// Pause arbiter: shares the core pause between user button, OSD and hiscore,
// pausing on vblank, granting hiscore RAM once settled, dimming after a timeout.
// Latency: pause 1 clk after vblank edge; grant SETTLE_CYC+1 clk after pause; RGB 1 clk.
// Backpressure: hs_req/hs_gnt handshake; a grant is held until hs_req drops.
// Ports: clk, reset_n, btn_pause, osd_status, osd_pause_en, hs_req, hs_gnt, vblank,
//        core_pause, dim, rgb_in, rgb_out, user_paused.
module pause_arbiter
    import pause_arbiter_pkg::*;
#(
    parameter int unsigned DIM_TIMEOUT  = DIM_TIMEOUT_DEF,
    parameter int unsigned SETTLE_CYC   = SETTLE_CYC_DEF,
    parameter int unsigned VBL_WAIT_MAX = VBL_WAIT_MAX_DEF,
    parameter int unsigned RGB_W        = RGB_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_pause,
    input  logic             osd_status,
    input  logic             osd_pause_en,
    input  logic             hs_req,
    output logic             hs_gnt,
    input  logic             vblank,
    output logic             core_pause,
    output logic             dim,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [RGB_W-1:0] rgb_out,
    output logic             user_paused
);

    state_t      state;
    state_t      state_nxt;
    logic        btn_q;
    logic        vbl_q;
    logic        toggle;
    logic        btn_rise;
    logic        vbl_rise;
    logic        toggle_nxt;
    logic        want;
    logic        in_pause;
    logic [31:0] vbl_cnt;
    logic [31:0] settle_cnt;
    logic [31:0] dim_cnt;

    assign btn_rise    = btn_pause & ~btn_q;
    assign vbl_rise    = vblank & ~vbl_q;
    assign toggle_nxt  = toggle ^ btn_rise;
    assign want        = toggle | (osd_status & osd_pause_en) | hs_req;
    assign in_pause    = (state == PAUSED) || (state == GRANT);
    assign user_paused = toggle;
    assign dim         = (dim_cnt == DIM_TIMEOUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q  <= 1'b0;
            vbl_q  <= 1'b0;
            toggle <= 1'b0;
            state  <= RUN;
        end else begin
            btn_q  <= btn_pause;
            vbl_q  <= vblank;
            toggle <= toggle_nxt;
            state  <= state_nxt;
        end
    end

    // Resume is unaligned: leaving PAUSED drops core_pause in the same cycle
    // want falls. GRANT ignores want entirely so a grant cannot be revoked.
    always_comb begin
        state_nxt  = state;
        core_pause = 1'b0;
        hs_gnt     = 1'b0;
        case (state)
            RUN: begin
                if (want) state_nxt = WAIT_VBL;
            end
            WAIT_VBL: begin
                if (!want) begin
                    state_nxt = RUN;
                end else if (vbl_rise || (vbl_cnt == VBL_WAIT_MAX - 1)) begin
                    state_nxt = PAUSED;
                end
            end
            PAUSED: begin
                core_pause = want;
                if (!want) begin
                    state_nxt = RUN;
                end else if (hs_req && (settle_cnt == SETTLE_CYC)) begin
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                core_pause = 1'b1;
                hs_gnt     = 1'b1;
                if (!hs_req) state_nxt = PAUSED;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Settle count survives GRANT->PAUSED so back-to-back hiscore requests
    // are granted after one cycle; only a real resume restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vbl_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            if (state == WAIT_VBL) begin
                vbl_cnt <= vbl_cnt + 32'd1;
            end else begin
                vbl_cnt <= '0;
            end
            if (in_pause) begin
                if (settle_cnt < SETTLE_CYC) settle_cnt <= settle_cnt + 32'd1;
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    // Dim timer follows the user toggle only; it clears on the same edge
    // that turns the toggle off so the undim is immediate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dim_cnt <= '0;
        end else if (!toggle_nxt) begin
            dim_cnt <= '0;
        end else if (toggle && in_pause && (dim_cnt != DIM_TIMEOUT)) begin
            dim_cnt <= dim_cnt + 32'd1;
        end
    end

    pause_arbiter_rgb_dimmer #(
        .RGB_W (RGB_W)
    ) u_dimmer (
        .clk     (clk),
        .reset_n (reset_n),
        .dim     (dim),
        .rgb_in  (rgb_in),
        .rgb_out (rgb_out)
    );

endmodule

// File: tb/tb_pause_arbiter.sv
// Bench for pause_arbiter with DIM_TIMEOUT=100, SETTLE_CYC=4, VBL_WAIT_MAX=50.
// Each scenario randomizes its gaps/colours and derives expected timing from
// the pause rules directly (vblank edge + 1, + settle + 1, timeout, dim count).
module tb_pause_arbiter;

    localparam int unsigned DIM_T  = 100;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned VBLMAX = 50;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_pause;
    logic       osd_status;
    logic       osd_pause_en;
    logic       hs_req;
    logic       hs_gnt;
    logic       vblank;
    logic       core_pause;
    logic       dim;
    logic [5:0] rgb_in;
    logic [5:0] rgb_out;
    logic       user_paused;

    int checks = 0;
    int passes = 0;

    pause_arbiter #(
        .DIM_TIMEOUT  (DIM_T),
        .SETTLE_CYC   (SETTLE),
        .VBL_WAIT_MAX (VBLMAX),
        .RGB_W        (6)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .btn_pause    (btn_pause),
        .osd_status   (osd_status),
        .osd_pause_en (osd_pause_en),
        .hs_req       (hs_req),
        .hs_gnt       (hs_gnt),
        .vblank       (vblank),
        .core_pause   (core_pause),
        .dim          (dim),
        .rgb_in       (rgb_in),
        .rgb_out      (rgb_out),
        .user_paused  (user_paused)
    );

    always #5 clk = ~clk;

    // Expected dimmed colour: each 2-bit channel divided by two.
    function automatic logic [5:0] halved(input logic [5:0] v);
        logic [1:0] r, g, b;
        r = v[5:4] / 2'd2;
        g = v[3:2] / 2'd2;
        b = v[1:0] / 2'd2;
        return {r, g, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press-and-release of the user button: toggle flips on the press edge.
    task automatic press();
        btn_pause = 1'b1;
        tick();
        btn_pause = 1'b0;
    endtask

    // From RUN with a pause request present: enter WAIT_VBL, then a vblank edge.
    task automatic pause_on_vblank();
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; btn_pause = 0; osd_status = 0; osd_pause_en = 0;
        hs_req = 0; vblank = 0; rgb_in = 6'h2a;
        #2;
        checks++; if (core_pause !== 1'b0) $display("FAIL reset_core_pause got=%b exp=0", core_pause); else passes++;
        checks++; if (hs_gnt !== 1'b0) $display("FAIL reset_hs_gnt got=%b exp=0", hs_gnt); else passes++;
        checks++; if (dim !== 1'b0) $display("FAIL reset_dim got=%b exp=0", dim); else passes++;
        checks++; if (rgb_out !== 6'h00) $display("FAIL reset_rgb got=%h exp=00", rgb_out); else passes++;
        checks++; if (user_paused !== 1'b0) $display("FAIL reset_user got=%b exp=0", user_paused); else passes++;
        #11 reset_n = 1'b1;
        tick();
        checks++; if (rgb_out !== 6'h2a) $display("FAIL rgb_passthru got=%h exp=2a", rgb_out); else passes++;
    endtask

    task automatic test_vblank_pause();
        int gap;
        gap = $urandom_range(3, 20);
        btn_pause = 1'b1;
        tick();
        btn_pause = 1'b0;
        checks++; if (user_paused !== 1'b1) $display("FAIL vp_toggle_on got=%b exp=1", user_paused); else passes++;
        tick();
        for (int i = 0; i < gap; i++) begin
            tick();
            checks++; if (core_pause !== 1'b0) $display("FAIL vp_wait got=%b exp=0 i=%0d", core_pause, i); else passes++;
        end
        vblank = 1'b1;
        #1;
        checks++; if (core_pause !== 1'b0) $display("FAIL vp_edge_cycle got=%b exp=0", core_pause); else passes++;
        tick();
        vblank = 1'b0;
        checks++; if (core_pause !== 1'b1) $display("FAIL vp_paused got=%b exp=1", core_pause); else passes++;
        tick();
        press();
        checks++; if (core_pause !== 1'b0) $display("FAIL vp_resume got=%b exp=0", core_pause); else passes++;
        checks++; if (user_paused !== 1'b0) $display("FAIL vp_toggle_off got=%b exp=0", user_paused); else passes++;
        tick();
        checks++; if (core_pause !== 1'b0) $display("FAIL vp_run got=%b exp=0", core_pause); else passes++;
    endtask

    task automatic test_hiscore_grant();
        int gap, hold;
        gap  = $urandom_range(2, 15);
        hold = $urandom_range(1, 10);
        hs_req = 1'b1;
        tick();
        for (int i = 0; i < gap; i++) tick();
        checks++; if (core_pause !== 1'b0) $display("FAIL hs_wait got=%b exp=0", core_pause); else passes++;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        checks++; if (core_pause !== 1'b1) $display("FAIL hs_paused got=%b exp=1", core_pause); else passes++;
        for (int i = 1; i <= int'(SETTLE); i++) begin
            tick();
            checks++; if (hs_gnt !== 1'b0) $display("FAIL hs_early_gnt got=%b exp=0 i=%0d", hs_gnt, i); else passes++;
        end
        tick();
        checks++; if (hs_gnt !== 1'b1) $display("FAIL hs_gnt_rise got=%b exp=1", hs_gnt); else passes++;
        for (int i = 0; i < hold; i++) tick();
        checks++; if (hs_gnt !== 1'b1 || core_pause !== 1'b1) $display("FAIL hs_hold got=%b%b exp=11", hs_gnt, core_pause); else passes++;
        hs_req = 1'b0;
        #1;
        checks++; if (hs_gnt !== 1'b1) $display("FAIL hs_gnt_lag got=%b exp=1", hs_gnt); else passes++;
        tick();
        checks++; if (hs_gnt !== 1'b0) $display("FAIL hs_gnt_fall got=%b exp=0", hs_gnt); else passes++;
        checks++; if (core_pause !== 1'b0) $display("FAIL hs_unpause got=%b exp=0", core_pause); else passes++;
        tick();
    endtask

    task automatic test_vblank_timeout();
        osd_pause_en = 1'b1;
        osd_status   = 1'b1;
        for (int i = 1; i <= int'(VBLMAX); i++) begin
            tick();
            checks++; if (core_pause !== 1'b0) $display("FAIL to_wait got=%b exp=0 i=%0d", core_pause, i); else passes++;
        end
        tick();
        checks++; if (core_pause !== 1'b1) $display("FAIL to_paused got=%b exp=1", core_pause); else passes++;
        osd_status = 1'b0;
        #1;
        checks++; if (core_pause !== 1'b0) $display("FAIL to_osd_close got=%b exp=0", core_pause); else passes++;
        tick();
        osd_pause_en = 1'b0;
        osd_status   = 1'b1;
        for (int i = 0; i < 60; i++) begin
            vblank = (i % 20) > 15;
            tick();
            checks++; if (core_pause !== 1'b0) $display("FAIL to_osd_disabled got=%b exp=0 i=%0d", core_pause, i); else passes++;
        end
        osd_status = 1'b0;
        vblank     = 1'b0;
        tick();
    endtask

    task automatic test_dim();
        logic [5:0] r;
        rgb_in = 6'b111111;
        press();
        pause_on_vblank();
        for (int k = 1; k < int'(DIM_T); k++) begin
            tick();
            checks++; if (dim !== 1'b0) $display("FAIL dim_early got=%b exp=0 k=%0d", dim, k); else passes++;
        end
        tick();
        checks++; if (dim !== 1'b1) $display("FAIL dim_on got=%b exp=1", dim); else passes++;
        checks++; if (rgb_out !== 6'b111111) $display("FAIL dim_rgb_lag got=%b exp=111111", rgb_out); else passes++;
        tick();
        checks++; if (rgb_out !== 6'b010101) $display("FAIL dim_rgb got=%b exp=010101", rgb_out); else passes++;
        for (int i = 0; i < 8; i++) begin
            r = 6'($urandom);
            rgb_in = r;
            tick();
            checks++; if (rgb_out !== halved(r)) $display("FAIL dim_rgb_rand got=%b exp=%b", rgb_out, halved(r)); else passes++;
        end
        hs_req = 1'b1;
        tick();
        checks++; if (hs_gnt !== 1'b1 || dim !== 1'b1) $display("FAIL dim_hs_grant got=%b%b exp=11", hs_gnt, dim); else passes++;
        hs_req = 1'b0;
        tick();
        osd_pause_en = 1'b1;
        osd_status   = 1'b1;
        tick(); tick();
        osd_status = 1'b0;
        tick();
        checks++; if (dim !== 1'b1 || core_pause !== 1'b1) $display("FAIL dim_kept got=%b%b exp=11", dim, core_pause); else passes++;
        osd_pause_en = 1'b0;
        rgb_in = 6'b111111;
        tick();
        press();
        checks++; if (dim !== 1'b0) $display("FAIL dim_clear got=%b exp=0", dim); else passes++;
        checks++; if (core_pause !== 1'b0) $display("FAIL dim_unpause got=%b exp=0", core_pause); else passes++;
        tick();
        checks++; if (rgb_out !== 6'b111111) $display("FAIL dim_rgb_restore got=%b exp=111111", rgb_out); else passes++;
    endtask

    task automatic test_grant_protection();
        int hold;
        hold = $urandom_range(2, 12);
        press();
        pause_on_vblank();
        for (int i = 0; i < 6; i++) tick();
        hs_req = 1'b1;
        tick();
        checks++; if (hs_gnt !== 1'b1) $display("FAIL gp_grant got=%b exp=1", hs_gnt); else passes++;
        press();
        checks++; if (user_paused !== 1'b0) $display("FAIL gp_toggle got=%b exp=0", user_paused); else passes++;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++; if (core_pause !== 1'b1 || hs_gnt !== 1'b1) $display("FAIL gp_hold got=%b%b exp=11", core_pause, hs_gnt); else passes++;
        end
        hs_req = 1'b0;
        tick();
        checks++; if (core_pause !== 1'b0 || hs_gnt !== 1'b0) $display("FAIL gp_release got=%b%b exp=00", core_pause, hs_gnt); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        n = $urandom_range(3, 5);
        osd_pause_en = 1'b1;
        osd_status   = 1'b1;
        pause_on_vblank();
        for (int i = 0; i < 6; i++) tick();
        for (int j = 0; j < n; j++) begin
            hs_req = 1'b1;
            tick();
            checks++; if (hs_gnt !== 1'b1) $display("FAIL b2b_grant got=%b exp=1 j=%0d", hs_gnt, j); else passes++;
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) tick();
            hs_req = 1'b0;
            tick();
            checks++; if (hs_gnt !== 1'b0 || core_pause !== 1'b1) $display("FAIL b2b_drop got=%b%b exp=01 j=%0d", hs_gnt, core_pause, j); else passes++;
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
        end
        osd_status = 1'b0;
        #1;
        checks++; if (core_pause !== 1'b0) $display("FAIL b2b_resume got=%b exp=0", core_pause); else passes++;
        osd_pause_en = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous();
        // Button edge and vblank edge together: the vblank edge arrives before
        // the request exists, so the pause must come from the wait timeout.
        btn_pause = 1'b1;
        vblank    = 1'b1;
        tick();
        btn_pause = 1'b0;
        checks++; if (user_paused !== 1'b1 || core_pause !== 1'b0) $display("FAIL sim_edge got=%b%b exp=10", user_paused, core_pause); else passes++;
        for (int k = 2; k <= int'(VBLMAX) + 1; k++) tick();
        checks++; if (core_pause !== 1'b0) $display("FAIL sim_wait got=%b exp=0", core_pause); else passes++;
        tick();
        checks++; if (core_pause !== 1'b1) $display("FAIL sim_paused got=%b exp=1", core_pause); else passes++;
        vblank = 1'b0;
        press();
        checks++; if (core_pause !== 1'b0) $display("FAIL sim_resume got=%b exp=0", core_pause); else passes++;
        tick();
    endtask

    task automatic test_async_reset();
        logic [5:0] r;
        r = 6'($urandom) | 6'h01;
        rgb_in = r;
        press();
        pause_on_vblank();
        for (int i = 0; i < 6; i++) tick();
        hs_req = 1'b1;
        tick();
        checks++; if (hs_gnt !== 1'b1 || rgb_out !== r) $display("FAIL ar_pre got=%b/%h exp=1/%h", hs_gnt, rgb_out, r); else passes++;
        #3 reset_n = 1'b0;
        #1;
        checks++; if (hs_gnt !== 1'b0) $display("FAIL ar_gnt got=%b exp=0", hs_gnt); else passes++;
        checks++; if (core_pause !== 1'b0) $display("FAIL ar_pause got=%b exp=0", core_pause); else passes++;
        checks++; if (dim !== 1'b0 || rgb_out !== 6'h00) $display("FAIL ar_video got=%b/%h exp=0/00", dim, rgb_out); else passes++;
        hs_req = 1'b0;
        #7 reset_n = 1'b1;
        tick();
        checks++; if (user_paused !== 1'b0) $display("FAIL ar_user got=%b exp=0", user_paused); else passes++;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
        checks++; if (core_pause !== 1'b0 || hs_gnt !== 1'b0) $display("FAIL ar_run got=%b%b exp=00", core_pause, hs_gnt); else passes++;
    endtask

    initial begin
        test_reset();
        test_vblank_pause();
        test_hiscore_grant();
        test_vblank_timeout();
        test_dim();
        test_grant_protection();
        test_back_to_back();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
